// File: rtl/redux_pkg.sv
// rtl/redux_pkg.sv - shared types and constants for the Redux core and its boot loader
package redux_pkg;

  typedef logic [7:0] byte_t;
  typedef logic [7:0] addr_t;

  localparam byte_t SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/redux_loader_timer.sv
// rtl/redux_loader_timer.sv - inter-byte idle counter for the boot loader
module redux_loader_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // Fires on the idle edge that would bring the count up to TIMEOUT.
  assign expired = (TIMEOUT > 0) && enable && !clear && (count == 16'(TIMEOUT - 1));

endmodule

// File: rtl/redux_loader.sv
// rtl/redux_loader.sv - framed byte-stream loader for the Redux instruction memory
module redux_loader
  import redux_pkg::*;
#(
  parameter addr_t START_ADDR = 8'h00,
  parameter byte_t SYNC_BYTE  = SYNC_BYTE_DEFAULT,
  parameter int    TIMEOUT    = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       cpu_reset,
  output logic       done,
  output logic       error
);

  loader_state_t state, state_next;
  logic [8:0]    count;
  byte_t         acc;
  byte_t         csum_sum;
  addr_t         next_addr;
  logic          xfer;
  logic          active;
  logic          expired;

  assign xfer     = in_valid && in_ready;
  assign active   = state inside {LEN, DATA, CSUM};
  assign csum_sum = acc + in_data;

  redux_loader_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (xfer || !active),
    .enable  (active),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = (state != DONE);
    case (state)
      IDLE, ERR: begin
        if (xfer && in_data == SYNC_BYTE) state_next = LEN;
      end
      LEN: begin
        if (xfer)         state_next = DATA;
        else if (expired) state_next = ERR;
      end
      DATA: begin
        if (xfer && count == 9'd1) state_next = CSUM;
        else if (expired)          state_next = ERR;
      end
      CSUM: begin
        if (xfer)         state_next = (csum_sum == 8'h00) ? DONE : ERR;
        else if (expired) state_next = ERR;
      end
      default: state_next = state;
    endcase
  end

  // Payload bytes reach the memory port exactly one cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= START_ADDR;
      imem_wdata <= 8'h00;
      count      <= 9'd0;
      acc        <= 8'h00;
      next_addr  <= START_ADDR;
    end else begin
      imem_we <= 1'b0;
      if (xfer && state == LEN) begin
        count     <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
        acc       <= 8'h00;
        next_addr <= START_ADDR;
      end else if (xfer && state == DATA) begin
        imem_we    <= 1'b1;
        imem_addr  <= next_addr;
        imem_wdata <= in_data;
        acc        <= csum_sum;
        next_addr  <= next_addr + 8'd1;
        count      <= count - 9'd1;
      end
    end
  end

  assign done      = (state == DONE);
  assign error     = (state == ERR);
  assign cpu_reset = (state != DONE);

endmodule

// File: tb/tb_redux_loader.sv
// tb/tb_redux_loader.sv - randomized and directed bench for redux_loader
module tb_redux_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid   [3];
  logic [7:0] in_data    [3];
  logic       in_ready   [3];
  logic       imem_we    [3];
  logic [7:0] imem_addr  [3];
  logic [7:0] imem_wdata [3];
  logic       cpu_reset  [3];
  logic       done       [3];
  logic       error      [3];

  always #5 clk = ~clk;

  redux_loader #(.START_ADDR(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT(255)) dut_a (
    .clk(clk), .reset(rst), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .imem_we(imem_we[0]), .imem_addr(imem_addr[0]), .imem_wdata(imem_wdata[0]),
    .cpu_reset(cpu_reset[0]), .done(done[0]), .error(error[0]));

  redux_loader #(.START_ADDR(8'hFE), .SYNC_BYTE(8'hA5), .TIMEOUT(255)) dut_b (
    .clk(clk), .reset(rst), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .imem_we(imem_we[1]), .imem_addr(imem_addr[1]), .imem_wdata(imem_wdata[1]),
    .cpu_reset(cpu_reset[1]), .done(done[1]), .error(error[1]));

  redux_loader #(.START_ADDR(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT(4)) dut_c (
    .clk(clk), .reset(rst), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .imem_we(imem_we[2]), .imem_addr(imem_addr[2]), .imem_wdata(imem_wdata[2]),
    .cpu_reset(cpu_reset[2]), .done(done[2]), .error(error[2]));

  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] got[$];
  logic [15:0] exp_w[$];
  logic [7:0]  stream[$];
  int          exp_status;

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (imem_we[k] === 1'b1) got.push_back({imem_addr[k], imem_wdata[k]});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame-level reference: 0 no frame, 1 loaded, 2 bad checksum, 3 frame cut short.
  task automatic model(input logic [7:0] start);
    int i = 0;
    int n;
    logic [7:0] s;
    exp_w.delete();
    exp_status = 0;
    while (i < stream.size()) begin
      if (stream[i] != 8'hA5) begin
        i++;
        continue;
      end
      i++;
      exp_status = 3;
      if (i >= stream.size()) break;
      n = (stream[i] == 8'h00) ? 256 : int'(stream[i]);
      i++;
      s = 8'h00;
      for (int k = 0; k < n && i < stream.size(); k++) begin
        exp_w.push_back({8'(int'(start) + k), stream[i]});
        s = s + stream[i];
        i++;
      end
      if (i >= stream.size()) break;
      exp_status = (8'(s + stream[i]) == 8'h00) ? 1 : 2;
      i++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int d, input logic [7:0] b);
    int w = 0;
    in_valid[d] = 1'b1;
    in_data[d]  = b;
    while (in_ready[d] !== 1'b1 && w < 20) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 20) check("in_ready_wait", 32'(in_ready[d]), 1);
    else begin
      @(posedge clk);
      #1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic run_stream(input int d, input logic [7:0] start, input int stall, input bit rnd, input string tag);
    model(start);
    got.delete();
    for (int i = 0; i < stream.size(); i++) begin
      send_byte(d, stream[i]);
      if (i != stream.size() - 1) idle(rnd ? int'($urandom_range(0, stall)) : stall);
    end
    if (exp_status == 1) begin
      check({tag, "_done"}, 32'(done[d]), 1);
      check({tag, "_cpu_reset"}, 32'(cpu_reset[d]), 0);
      check({tag, "_in_ready"}, 32'(in_ready[d]), 0);
      check({tag, "_error"}, 32'(error[d]), 0);
    end else if (exp_status == 2) begin
      check({tag, "_error"}, 32'(error[d]), 1);
      check({tag, "_done"}, 32'(done[d]), 0);
      check({tag, "_cpu_reset"}, 32'(cpu_reset[d]), 1);
    end
    idle(1);
    check({tag, "_nwrites"}, 32'(got.size()), 32'(exp_w.size()));
    for (int k = 0; k < got.size() && k < exp_w.size(); k++)
      check({tag, "_write"}, 32'(got[k]), 32'(exp_w[k]));
  endtask

  initial begin
    int nfr;
    int len;
    logic [7:0] s;
    logic [7:0] b;

    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0;
      in_data[k]  = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    check("rst_in_ready", 32'(in_ready[0]), 1);
    check("rst_imem_we", 32'(imem_we[0]), 0);
    check("rst_imem_addr", 32'(imem_addr[0]), 32'h00);
    check("rst_imem_addr_b", 32'(imem_addr[1]), 32'hFE);
    check("rst_cpu_reset", 32'(cpu_reset[0]), 1);
    check("rst_done", 32'(done[0]), 0);
    check("rst_error", 32'(error[0]), 0);

    stream = '{8'h00, 8'h42, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_stream(0, 8'h00, 0, 1'b0, "nominal");
    check("nominal_w0", 32'(got[0]), 32'h0011);
    check("nominal_w2", 32'(got[2]), 32'h0233);
    in_valid[0] = 1'b1;
    in_data[0]  = 8'hA5;
    idle(3);
    in_valid[0] = 1'b0;
    check("done_ignores_writes", 32'(got.size()), 3);
    check("done_holds", 32'(done[0]), 1);

    do_reset();
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    run_stream(0, 8'h00, 0, 1'b0, "badcsum");
    check("badcsum_flag", 32'(error[0]), 1);
    stream = '{8'hA5, 8'h01, 8'h07, 8'hF9};
    run_stream(0, 8'h00, 0, 1'b0, "recover");
    check("recover_w0", 32'(got[0]), 32'h0007);

    stream = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    run_stream(1, 8'hFE, 0, 1'b0, "wrap");
    check("wrap_w0", 32'(got[0]), 32'hFE01);
    check("wrap_w2", 32'(got[2]), 32'h0003);

    do_reset();
    stream = '{8'hA5, 8'h00};
    repeat (256) stream.push_back(8'h01);
    stream.push_back(8'h00);
    run_stream(0, 8'h00, 0, 1'b0, "long");

    do_reset();
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_stream(0, 8'h00, 5, 1'b0, "stall");

    got.delete();
    send_byte(2, 8'hA5);
    send_byte(2, 8'h03);
    send_byte(2, 8'h11);
    idle(3);
    check("timeout_early", 32'(error[2]), 0);
    idle(1);
    check("timeout_error", 32'(error[2]), 1);
    check("timeout_cpu_reset", 32'(cpu_reset[2]), 1);
    check("timeout_nwrites", 32'(got.size()), 1);
    check("timeout_w0", 32'(got[0]), 32'h0011);
    stream = '{8'hA5, 8'h01, 8'h07, 8'hF9};
    run_stream(2, 8'h00, 0, 1'b0, "timeout_restart");

    do_reset();
    got.delete();
    send_byte(1, 8'hA5);
    send_byte(1, 8'h03);
    send_byte(1, 8'h11);
    send_byte(1, 8'h22);
    #2;
    rst = 1'b1;
    #1;
    check("arst_imem_we", 32'(imem_we[1]), 0);
    check("arst_imem_addr", 32'(imem_addr[1]), 32'hFE);
    check("arst_cpu_reset", 32'(cpu_reset[1]), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check("arst_nwrites", 32'(got.size()), 1);
    stream = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    run_stream(1, 8'hFE, 0, 1'b0, "post_reset");

    for (int it = 0; it < 6; it++) begin
      do_reset();
      stream.delete();
      nfr = int'($urandom_range(1, 3));
      for (int f = 0; f < nfr; f++) begin
        repeat ($urandom_range(0, 2)) begin
          b = 8'($urandom_range(0, 255));
          stream.push_back((b == 8'hA5) ? 8'h00 : b);
        end
        len = int'($urandom_range(1, 24));
        stream.push_back(8'hA5);
        stream.push_back(8'(len));
        s = 8'h00;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          stream.push_back(b);
          s = s + b;
        end
        s = 8'h00 - s;
        if (f != nfr - 1 || $urandom_range(0, 3) == 0) s = s + 8'($urandom_range(1, 255));
        stream.push_back(s);
      end
      run_stream(0, 8'h00, 3, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
